// File: rtl/imm_select_pipe_rv.sv
// Pipelined RV immediate generator: decodes the immediate at the input and queues
// results in a 2-entry (main + skid) valid/ready buffer, with tag pass-through and an illegal-type counter.
module imm_select_pipe_rv #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_instr,
    input  logic [2:0]       in_immtype,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    input  logic             clr_err,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        st_empty = 2'd0,
        st_one   = 2'd1,
        st_two   = 2'd2
    } state_t;

    localparam logic [2:0] T_I  = 3'b000;
    localparam logic [2:0] T_S  = 3'b001;
    localparam logic [2:0] T_B  = 3'b010;
    localparam logic [2:0] T_U  = 3'b011;
    localparam logic [2:0] T_J  = 3'b100;
    localparam logic [2:0] T_Z  = 3'b101;
    localparam logic [2:0] T_SH = 3'b110;

    function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t state, state_nxt;

    logic                    s;
    logic signed [XLEN-1:0]  imm_p0;
    logic                    err_p0;
    logic [XLEN-1:0]         imm_p1, imm_sk;
    logic [TAG_W-1:0]        tag_p1, tag_sk;
    logic                    err_p1, err_sk;
    logic [CNT_W-1:0]        cnt_p1;
    logic                    accept, drain;
    logic                    load_main_in, load_skid_in, load_main_skid;

    // Stage p0: combinational immediate decode on the incoming beat
    assign s = in_instr[24];

    always_comb begin
        imm_p0 = '0;
        err_p0 = 1'b0;
        case (in_immtype)
            T_I:  imm_p0 = sext32({{20{s}}, in_instr[24:13]});
            T_S:  imm_p0 = sext32({{20{s}}, in_instr[24:18], in_instr[4:0]});
            T_B:  imm_p0 = sext32({{20{s}}, in_instr[0], in_instr[23:18], in_instr[4:1], 1'b0});
            T_U:  imm_p0 = sext32({in_instr[24:5], 12'h000});
            T_J:  imm_p0 = sext32({{12{s}}, in_instr[12:5], in_instr[13], in_instr[23:14], 1'b0});
            T_Z:  imm_p0 = XLEN'(in_instr[12:8]);
            T_SH: imm_p0 = (XLEN == 64) ? XLEN'(in_instr[18:13]) : XLEN'(in_instr[17:13]);
            default: err_p0 = 1'b1;
        endcase
    end

    // Handshake and buffer control derive only from registered state
    assign in_ready  = (state != st_two);
    assign out_valid = (state != st_empty);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_skid_in   = 1'b0;
        load_main_skid = 1'b0;
        case (state)
            st_empty: begin
                if (accept) begin
                    load_main_in = 1'b1;
                    state_nxt    = st_one;
                end
            end
            st_one: begin
                if (accept && drain) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    load_skid_in = 1'b1;
                    state_nxt    = st_two;
                end else if (drain) begin
                    state_nxt = st_empty;
                end
            end
            st_two: begin
                if (drain) begin
                    load_main_skid = 1'b1;
                    state_nxt      = st_one;
                end
            end
            default: state_nxt = st_empty;
        endcase
    end

    // Stage p1: main/skid registers and error counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= st_empty;
            imm_p1 <= '0;
            tag_p1 <= '0;
            err_p1 <= 1'b0;
            imm_sk <= '0;
            tag_sk <= '0;
            err_sk <= 1'b0;
            cnt_p1 <= '0;
        end else begin
            state <= state_nxt;
            if (load_main_in) begin
                imm_p1 <= imm_p0;
                tag_p1 <= in_tag;
                err_p1 <= err_p0;
            end else if (load_main_skid) begin
                imm_p1 <= imm_sk;
                tag_p1 <= tag_sk;
                err_p1 <= err_sk;
            end
            if (load_skid_in) begin
                imm_sk <= imm_p0;
                tag_sk <= in_tag;
                err_sk <= err_p0;
            end else if (load_main_skid) begin
                imm_sk <= '0;
                tag_sk <= '0;
                err_sk <= 1'b0;
            end
            // Clear wins over a same-cycle illegal accept
            if (clr_err)
                cnt_p1 <= '0;
            else if (accept && err_p0)
                cnt_p1 <= sat_inc(cnt_p1);
        end
    end

    assign out_imm   = imm_p1;
    assign out_tag   = tag_p1;
    assign out_err   = err_p1;
    assign err_count = cnt_p1;

endmodule
